// File: rtl/mioc_sync_detect.sv
// mioc_sync_detect: serial sync-word detector with hunt/verify/lock framing.
// A WIDTH-bit sliding window is compared to a programmable pattern through a
// bank of XNOR cells. A flywheel state machine turns frame-aligned hits into
// lock status, a sync pulse and a per-frame boundary pulse.
module mioc_sync_detect #(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 32,
  parameter  int MISS_MAX  = 2,
  parameter  int TOL       = 0,
  localparam int MW        = $clog2(MISS_MAX + 1),
  localparam int AW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] pattern,
  output logic             locked,
  output logic [1:0]       state,
  output logic             sync_pulse,
  output logic             frame_pulse,
  output logic [MW-1:0]    miss_cnt,
  output logic [AW-1:0]    agree_cnt
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] win_next;
  logic [AW-1:0]    fill_reg, fill_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [MW-1:0]    miss_reg, miss_next;
  logic             locked_reg;
  logic             sync_reg, sync_next;
  logic             frame_reg, frame_next;
  logic [WIDTH-1:0] eq_cur, eq_win;
  logic [AW-1:0]    agree_cur, agree_win;
  logic             hit, boundary, last_miss;

  // Window as it will look after this edge's bit is shifted in (newest = LSB).
  assign win_next = {sr_reg[WIDTH-2:0], in_bit};

  // XNOR equality cells: one per bit for the registered window and for the
  // window being formed on this edge.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_eq
      assign eq_cur[gi] = ~(sr_reg[gi] ^ pattern[gi]);
      assign eq_win[gi] = ~(win_next[gi] ^ pattern[gi]);
    end
  endgenerate

  // Count agreeing bits in both windows.
  always_comb begin
    agree_cur = '0;
    agree_win = '0;
    for (int i = 0; i < WIDTH; i++) begin
      agree_cur = agree_cur + AW'(eq_cur[i]);
      agree_win = agree_win + AW'(eq_win[i]);
    end
  end

  // Fill saturates at WIDTH; a comparison only counts once the window is full.
  assign fill_next = (fill_reg == AW'(WIDTH)) ? fill_reg : fill_reg + AW'(1);
  assign hit       = in_valid && (fill_next == AW'(WIDTH))
                     && (agree_win >= AW'(WIDTH - TOL));
  assign boundary  = in_valid && (bit_cnt_reg == BW'(FRAME_LEN - 1));
  assign last_miss = (miss_reg == MW'(MISS_MAX - 1));

  // Next-state, frame counter, miss counter and pulse decisions.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    miss_next    = miss_reg;
    sync_next    = 1'b0;
    frame_next   = 1'b0;
    if (in_valid) begin
      case (state_reg)
        SEARCH: begin
          bit_cnt_next = '0;
          if (hit) begin
            state_next = VERIFY;
            sync_next  = 1'b1;
          end
        end
        VERIFY: begin
          if (boundary) begin
            bit_cnt_next = '0;
            frame_next   = 1'b1;
            if (hit) begin
              state_next = LOCKED;
              sync_next  = 1'b1;
            end else begin
              state_next = SEARCH;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
        LOCKED: begin
          if (boundary) begin
            bit_cnt_next = '0;
            frame_next   = 1'b1;
            if (hit) begin
              miss_next = '0;
              sync_next = 1'b1;
            end else if (last_miss) begin
              miss_next  = '0;
              state_next = SEARCH;
            end else begin
              miss_next = miss_reg + MW'(1);
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
        default: begin
          state_next   = SEARCH;
          bit_cnt_next = '0;
          miss_next    = '0;
        end
      endcase
    end
  end

  // State, window and counters advance on accepting edges; pulses always refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SEARCH;
      sr_reg      <= '0;
      fill_reg    <= '0;
      bit_cnt_reg <= '0;
      miss_reg    <= '0;
      locked_reg  <= 1'b0;
      sync_reg    <= 1'b0;
      frame_reg   <= 1'b0;
    end else begin
      sync_reg    <= sync_next;
      frame_reg   <= frame_next;
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      miss_reg    <= miss_next;
      locked_reg  <= (state_next == LOCKED);
      if (in_valid) begin
        sr_reg   <= win_next;
        fill_reg <= fill_next;
      end
    end
  end

  assign locked      = locked_reg;
  assign state       = state_reg;
  assign sync_pulse  = sync_reg;
  assign frame_pulse = frame_reg;
  assign miss_cnt    = miss_reg;
  assign agree_cnt   = agree_cur;

endmodule

// File: tb/tb_mioc_sync_detect.sv
// Self-checking bench for mioc_sync_detect: two instances (TOL=0 and TOL=1)
// share one stimulus stream; a bit-history reference model predicts both.
`timescale 1ns/1ps
module tb_mioc_sync_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic [7:0] pattern;

  logic       dut_locked [2];
  logic [1:0] dut_state  [2];
  logic       dut_sync   [2];
  logic       dut_frame  [2];
  logic [1:0] dut_miss   [2];
  logic [3:0] dut_agree  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: window of the last 8 accepted bits, bits accepted since
  // the last sync word, and the search/verify/locked status.
  logic [7:0] m_win   [2];
  int         m_fill  [2];
  int         m_state [2];
  int         m_phase [2];
  int         m_miss  [2];
  bit         m_sync  [2];
  bit         m_frame [2];
  int         tol_of  [2] = '{0, 1};

  always #5 clk = ~clk;

  mioc_sync_detect #(.WIDTH(8), .FRAME_LEN(16), .MISS_MAX(2), .TOL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .pattern(pattern),
    .locked(dut_locked[0]), .state(dut_state[0]), .sync_pulse(dut_sync[0]),
    .frame_pulse(dut_frame[0]), .miss_cnt(dut_miss[0]), .agree_cnt(dut_agree[0])
  );

  mioc_sync_detect #(.WIDTH(8), .FRAME_LEN(16), .MISS_MAX(2), .TOL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .pattern(pattern),
    .locked(dut_locked[1]), .state(dut_state[1]), .sync_pulse(dut_sync[1]),
    .frame_pulse(dut_frame[1]), .miss_cnt(dut_miss[1]), .agree_cnt(dut_agree[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_win[k] = '0; m_fill[k] = 0; m_state[k] = 0; m_phase[k] = 0;
      m_miss[k] = 0; m_sync[k] = 0; m_frame[k] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic b);
    int agree;
    bit hit;
    for (int k = 0; k < 2; k++) begin
      m_sync[k]  = 0;
      m_frame[k] = 0;
      if (v) begin
        m_win[k] = {m_win[k][6:0], b};
        if (m_fill[k] < 8) m_fill[k]++;
        agree = $countones(~(m_win[k] ^ pattern));
        hit   = (m_fill[k] == 8) && (agree >= 8 - tol_of[k]);
        if (m_state[k] == 0) begin
          if (hit) begin
            m_state[k] = 1; m_phase[k] = 0; m_sync[k] = 1;
          end
        end else begin
          m_phase[k]++;
          if (m_phase[k] == 16) begin
            m_phase[k] = 0;
            m_frame[k] = 1;
            if (hit) begin
              m_state[k] = 2; m_miss[k] = 0; m_sync[k] = 1;
            end else if (m_state[k] == 1) begin
              m_state[k] = 0;
            end else begin
              m_miss[k]++;
              if (m_miss[k] == 2) begin
                m_state[k] = 0; m_miss[k] = 0;
              end
            end
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, settle.
  task automatic drive(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    model_step(v, b);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; pattern = 8'hA7;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      tests_run++; if (dut_locked[k] !== 1'b0) begin tests_failed++; $display("FAIL rst_locked[%0d] got=%0b exp=0", k, dut_locked[k]); end
      tests_run++; if (dut_state[k] !== 2'd0) begin tests_failed++; $display("FAIL rst_state[%0d] got=%0d exp=0", k, dut_state[k]); end
      tests_run++; if (dut_sync[k] !== 1'b0) begin tests_failed++; $display("FAIL rst_sync[%0d] got=%0b exp=0", k, dut_sync[k]); end
      tests_run++; if (dut_frame[k] !== 1'b0) begin tests_failed++; $display("FAIL rst_frame[%0d] got=%0b exp=0", k, dut_frame[k]); end
      tests_run++; if (dut_miss[k] !== 2'd0) begin tests_failed++; $display("FAIL rst_miss[%0d] got=%0d exp=0", k, dut_miss[k]); end
      tests_run++; if (dut_agree[k] !== 4'd3) begin tests_failed++; $display("FAIL rst_agree[%0d] got=%0d exp=3", k, dut_agree[k]); end
    end
    $display("[TB] reset: held low, outputs sampled");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_acquire();
    logic [15:0] fr;
    fr = {8'h00, 8'hA7};
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, fr[i]);
      if (i != 0) begin
        tests_run++; if (dut_sync[0] !== 1'b0) begin tests_failed++; $display("FAIL acq_early_sync bit=%0d got=%0b exp=0", 15 - i, dut_sync[0]); end
      end
    end
    tests_run++; if (dut_sync[0] !== 1'b1) begin tests_failed++; $display("FAIL acq_sync got=%0b exp=1", dut_sync[0]); end
    tests_run++; if (dut_state[0] !== 2'd1) begin tests_failed++; $display("FAIL acq_state got=%0d exp=1", dut_state[0]); end
    tests_run++; if (dut_locked[0] !== 1'b0) begin tests_failed++; $display("FAIL acq_locked got=%0b exp=0", dut_locked[0]); end
    $display("[TB] acquire: sent 00 A7, state=%0d sync=%0b", dut_state[0], dut_sync[0]);
  endtask

  task automatic test_lock();
    logic [15:0] fr;
    fr = {8'($urandom), 8'hA7};
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, fr[i]);
      if (i != 0) begin
        tests_run++; if ((dut_sync[0] | dut_frame[0]) !== 1'b0) begin tests_failed++; $display("FAIL lock_early_pulse bit=%0d got=%0b%0b exp=00", 15 - i, dut_sync[0], dut_frame[0]); end
      end
    end
    tests_run++; if (dut_sync[0] !== 1'b1) begin tests_failed++; $display("FAIL lock_sync got=%0b exp=1", dut_sync[0]); end
    tests_run++; if (dut_frame[0] !== 1'b1) begin tests_failed++; $display("FAIL lock_frame got=%0b exp=1", dut_frame[0]); end
    tests_run++; if (dut_state[0] !== 2'd2) begin tests_failed++; $display("FAIL lock_state got=%0d exp=2", dut_state[0]); end
    tests_run++; if (dut_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL lock_locked got=%0b exp=1", dut_locked[0]); end
    $display("[TB] lock: sent payload+A7, state=%0d", dut_state[0]);
    // Sync word sitting off the boundary must not produce any pulse.
    fr = {8'hA7, 8'hA7};
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, fr[i]);
      if (i != 0) begin
        tests_run++; if ((dut_sync[0] | dut_frame[0]) !== 1'b0) begin tests_failed++; $display("FAIL offset_pulse bit=%0d got=%0b%0b exp=00", 15 - i, dut_sync[0], dut_frame[0]); end
      end
    end
    tests_run++; if ((dut_sync[0] & dut_frame[0]) !== 1'b1) begin tests_failed++; $display("FAIL offset_boundary got=%0b%0b exp=11", dut_sync[0], dut_frame[0]); end
    $display("[TB] lock: sent A7 A7 (off-boundary copy), locked=%0b", dut_locked[0]);
  endtask

  task automatic test_flywheel();
    logic [15:0] fr;
    fr = {8'($urandom), 8'hA6};
    for (int i = 15; i >= 0; i--) drive(1'b1, fr[i]);
    tests_run++; if (dut_frame[0] !== 1'b1) begin tests_failed++; $display("FAIL fly_frame got=%0b exp=1", dut_frame[0]); end
    tests_run++; if (dut_sync[0] !== 1'b0) begin tests_failed++; $display("FAIL fly_sync got=%0b exp=0", dut_sync[0]); end
    tests_run++; if (dut_miss[0] !== 2'd1) begin tests_failed++; $display("FAIL fly_miss got=%0d exp=1", dut_miss[0]); end
    tests_run++; if (dut_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL fly_locked got=%0b exp=1", dut_locked[0]); end
    $display("[TB] flywheel: sent payload+A6, miss_cnt=%0d", dut_miss[0]);
    fr = {8'($urandom), 8'hA7};
    for (int i = 15; i >= 0; i--) drive(1'b1, fr[i]);
    tests_run++; if (dut_miss[0] !== 2'd0) begin tests_failed++; $display("FAIL fly_recover_miss got=%0d exp=0", dut_miss[0]); end
    tests_run++; if (dut_sync[0] !== 1'b1) begin tests_failed++; $display("FAIL fly_recover_sync got=%0b exp=1", dut_sync[0]); end
    $display("[TB] flywheel: sent payload+A7, miss_cnt=%0d", dut_miss[0]);
  endtask

  task automatic test_loss();
    logic [15:0] fr;
    fr = {8'($urandom), 8'h3C};
    for (int i = 15; i >= 0; i--) drive(1'b1, fr[i]);
    tests_run++; if (dut_miss[0] !== 2'd1) begin tests_failed++; $display("FAIL loss_miss1 got=%0d exp=1", dut_miss[0]); end
    $display("[TB] loss: sent payload+3C, miss_cnt=%0d", dut_miss[0]);
    fr = {8'($urandom), 8'h5A};
    for (int i = 15; i >= 0; i--) drive(1'b1, fr[i]);
    tests_run++; if (dut_state[0] !== 2'd0) begin tests_failed++; $display("FAIL loss_state got=%0d exp=0", dut_state[0]); end
    tests_run++; if (dut_locked[0] !== 1'b0) begin tests_failed++; $display("FAIL loss_locked got=%0b exp=0", dut_locked[0]); end
    tests_run++; if (dut_miss[0] !== 2'd0) begin tests_failed++; $display("FAIL loss_miss got=%0d exp=0", dut_miss[0]); end
    tests_run++; if (dut_frame[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_frame got=%0b exp=1", dut_frame[0]); end
    $display("[TB] loss: sent payload+5A, state=%0d", dut_state[0]);
    fr = {8'h00, 8'hA7};
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, fr[i]);
      if (i != 0) begin
        tests_run++; if (dut_sync[0] !== 1'b0) begin tests_failed++; $display("FAIL reacq_early_sync bit=%0d got=%0b exp=0", 7 - i, dut_sync[0]); end
      end
    end
    tests_run++; if (dut_sync[0] !== 1'b1) begin tests_failed++; $display("FAIL reacq_sync got=%0b exp=1", dut_sync[0]); end
    tests_run++; if (dut_state[0] !== 2'd1) begin tests_failed++; $display("FAIL reacq_state got=%0d exp=1", dut_state[0]); end
    $display("[TB] loss: sent A7, re-acquired state=%0d", dut_state[0]);
  endtask

  task automatic test_gapped();
    logic [15:0] fr;
    int sc, fc;
    sc = 0; fc = 0;
    fr = {8'($urandom), 8'hA7};
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, fr[i]);
      sc += int'(dut_sync[0]); fc += int'(dut_frame[0]);
      if (i == 0) begin
        tests_run++; if ((dut_sync[0] & dut_frame[0]) !== 1'b1) begin tests_failed++; $display("FAIL gap_boundary got=%0b%0b exp=11", dut_sync[0], dut_frame[0]); end
        tests_run++; if (dut_state[0] !== 2'd2) begin tests_failed++; $display("FAIL gap_state got=%0d exp=2", dut_state[0]); end
      end
      drive(1'b0, 1'($urandom));
      tests_run++; if ((dut_sync[0] | dut_frame[0]) !== 1'b0) begin tests_failed++; $display("FAIL gap_idle_pulse bit=%0d got=%0b%0b exp=00", 15 - i, dut_sync[0], dut_frame[0]); end
    end
    tests_run++; if (sc !== 1) begin tests_failed++; $display("FAIL gap_sync_count got=%0d exp=1", sc); end
    tests_run++; if (fc !== 1) begin tests_failed++; $display("FAIL gap_frame_count got=%0d exp=1", fc); end
    $display("[TB] gapped: sent payload+A7 with gaps, sync=%0d frame=%0d", sc, fc);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom));
    tests_run++; if (dut_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_locked got=%0b exp=1", dut_locked[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      tests_run++; if (dut_locked[k] !== 1'b0) begin tests_failed++; $display("FAIL arst_locked[%0d] got=%0b exp=0", k, dut_locked[k]); end
      tests_run++; if (dut_state[k] !== 2'd0) begin tests_failed++; $display("FAIL arst_state[%0d] got=%0d exp=0", k, dut_state[k]); end
      tests_run++; if (dut_agree[k] !== 4'd3) begin tests_failed++; $display("FAIL arst_agree[%0d] got=%0d exp=3", k, dut_agree[k]); end
    end
    $display("[TB] async reset: asserted mid-frame, state=%0d locked=%0b", dut_state[0], dut_locked[0]);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tolerance();
    logic [15:0] fr;
    fr = {8'h00, 8'hA6};
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, fr[i]);
      if (i != 0) begin
        tests_run++; if (dut_sync[1] !== 1'b0) begin tests_failed++; $display("FAIL tol_early_sync bit=%0d got=%0b exp=0", 15 - i, dut_sync[1]); end
      end
    end
    tests_run++; if (dut_sync[1] !== 1'b1) begin tests_failed++; $display("FAIL tol_hit_sync got=%0b exp=1", dut_sync[1]); end
    tests_run++; if (dut_state[1] !== 2'd1) begin tests_failed++; $display("FAIL tol_hit_state got=%0d exp=1", dut_state[1]); end
    tests_run++; if (dut_agree[1] !== 4'd7) begin tests_failed++; $display("FAIL tol_agree got=%0d exp=7", dut_agree[1]); end
    tests_run++; if (dut_sync[0] !== 1'b0) begin tests_failed++; $display("FAIL tol0_no_hit got=%0b exp=0", dut_sync[0]); end
    $display("[TB] tolerance: sent 00 A6, tol1 sync=%0b agree=%0d", dut_sync[1], dut_agree[1]);
    fr = {8'($urandom), 8'hA4};
    for (int i = 15; i >= 0; i--) drive(1'b1, fr[i]);
    tests_run++; if (dut_frame[1] !== 1'b1) begin tests_failed++; $display("FAIL tol_miss_frame got=%0b exp=1", dut_frame[1]); end
    tests_run++; if (dut_sync[1] !== 1'b0) begin tests_failed++; $display("FAIL tol_miss_sync got=%0b exp=0", dut_sync[1]); end
    tests_run++; if (dut_state[1] !== 2'd0) begin tests_failed++; $display("FAIL tol_miss_state got=%0d exp=0", dut_state[1]); end
    tests_run++; if (dut_agree[1] !== 4'd6) begin tests_failed++; $display("FAIL tol_miss_agree got=%0d exp=6", dut_agree[1]); end
    $display("[TB] tolerance: sent payload+A4, tol1 state=%0d", dut_state[1]);
  endtask

  task automatic test_random();
    logic [15:0] fr;
    logic [7:0]  sw;
    logic        v;
    int          i;
    int          exp_agree;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if (f == 20) pattern = 8'h3C;
      if (f == 32) pattern = 8'hA7;
      sw = ($urandom_range(0, 3) != 0) ? pattern : 8'($urandom);
      fr = {8'($urandom), sw};
      i = 15;
      while (i >= 0) begin
        v = ($urandom_range(0, 3) != 0);
        drive(v, v ? fr[i] : 1'($urandom));
        if (v) i--;
        for (int k = 0; k < 2; k++) begin
          exp_agree = $countones(~(m_win[k] ^ pattern));
          tests_run++; if (dut_state[k] !== 2'(m_state[k])) begin tests_failed++; $display("FAIL rnd_state[%0d] f=%0d got=%0d exp=%0d", k, f, dut_state[k], m_state[k]); end
          tests_run++; if (dut_locked[k] !== (m_state[k] == 2)) begin tests_failed++; $display("FAIL rnd_locked[%0d] f=%0d got=%0b exp=%0b", k, f, dut_locked[k], m_state[k] == 2); end
          tests_run++; if (dut_sync[k] !== m_sync[k]) begin tests_failed++; $display("FAIL rnd_sync[%0d] f=%0d got=%0b exp=%0b", k, f, dut_sync[k], m_sync[k]); end
          tests_run++; if (dut_frame[k] !== m_frame[k]) begin tests_failed++; $display("FAIL rnd_frame[%0d] f=%0d got=%0b exp=%0b", k, f, dut_frame[k], m_frame[k]); end
          tests_run++; if (dut_miss[k] !== 2'(m_miss[k])) begin tests_failed++; $display("FAIL rnd_miss[%0d] f=%0d got=%0d exp=%0d", k, f, dut_miss[k], m_miss[k]); end
          tests_run++; if (dut_agree[k] !== 4'(exp_agree)) begin tests_failed++; $display("FAIL rnd_agree[%0d] f=%0d got=%0d exp=%0d", k, f, dut_agree[k], exp_agree); end
        end
      end
      $display("[TB] random frame %0d: pattern=%h sync=%h state0=%0d state1=%0d", f, pattern, sw, dut_state[0], dut_state[1]);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_lock();
    test_flywheel();
    test_loss();
    test_gapped();
    test_async_reset();
    test_tolerance();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
